// File: rtl/ads868x_spi_emu.sv
// ADS868x SPI responder emulator: decodes 32-clock frames from our SPI master and returns stream-fed samples.
// Optional build macro ADS868X_EMU_AUTO_SEQ_EN adds AUTO_RST / NO_OP channel auto-sequencing.
module ads868x_spi_emu #(
  parameter int C_NUM_CH      = 8,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        SCK,
  input  logic        SS_N,
  input  logic        SDI,
  output logic        SDO,
  output logic        SDO_T,
  input  logic [15:0] s_axis_tdata,
  input  logic [2:0]  s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        frame_done,
  output logic [15:0] last_cmd,
  output logic [2:0]  ch_sel,
  output logic [7:0]  err_cnt
);
  localparam int CH_W = $clog2(C_NUM_CH);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_CMD, S_DATA, S_OVER, S_EXEC
  } state_t;

  state_t state_q, state_d;

  logic [C_SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, sdi_sync_q;
  logic sck_prev_q, ss_prev_q;
  logic sck_s, ss_s, sdi_s;
  logic sck_rise, sck_fall, ss_rise, ss_fall;

  logic [5:0]  bit_cnt_q;
  logic [15:0] cmd_q, data_q, last_cmd_q, load_word, cmd_full;
  logic        sdo_q, sdo_next, tready_q;
  logic [7:0]  err_cnt_q;
  logic [2:0]  ch_sel_q, ch_sel_d;
  logic [7:0]  reg_q  [64];
  logic [15:0] samp_q [C_NUM_CH];

  logic in_frame, abort, exec;
  logic cmd_rst, cmd_man, cmd_wr;
  logic sdo_t_c, frame_done_c;

`ifdef ADS868X_EMU_AUTO_SEQ_EN
  logic                auto_q, auto_d, cmd_auto;
  logic [C_NUM_CH-1:0] en_mask;
  logic [CH_W-1:0]     nxt_idx;
`endif

  // SS_N chain resets low so leaving WAIT_IDLE needs a genuinely observed SS_N high
  always_ff @(posedge aclk) begin
    if (areset) begin
      sck_sync_q <= '0;
      ss_sync_q  <= '0;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      ss_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[C_SYNC_STAGES-2:0], SCK};
      ss_sync_q  <= {ss_sync_q[C_SYNC_STAGES-2:0], SS_N};
      sdi_sync_q <= {sdi_sync_q[C_SYNC_STAGES-2:0], SDI};
      sck_prev_q <= sck_s;
      ss_prev_q  <= ss_s;
    end
  end

  assign sck_s    = sck_sync_q[C_SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[C_SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[C_SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  assign in_frame = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_OVER);
  assign abort    = ss_rise && ((state_q == S_CMD) || (state_q == S_DATA));
  assign exec     = (state_q == S_EXEC);

  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_WAIT_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_IDLE: if (ss_s) state_d = S_IDLE;
      S_IDLE:      if (ss_fall) state_d = S_CMD;
      S_CMD: begin
        if (ss_rise)                                 state_d = S_IDLE;
        else if (sck_rise && bit_cnt_q == 6'd15)     state_d = S_DATA;
      end
      S_DATA: begin
        if (ss_rise)                                 state_d = S_IDLE;
        else if (sck_rise && bit_cnt_q == 6'd31)     state_d = S_OVER;
      end
      S_OVER:      if (ss_rise) state_d = S_EXEC;
      S_EXEC:      state_d = S_IDLE;
      default:     state_d = S_WAIT_IDLE;
    endcase
  end

  always_comb begin
    sdo_t_c      = ~in_frame;
    frame_done_c = exec;
  end

  // The 16th SDI bit is still in the synchronizer when the data half is loaded
  assign cmd_full = {cmd_q[14:0], sdi_s};

  always_comb begin
    load_word = samp_q[ch_sel_q[CH_W-1:0]];
    if (!cmd_full[15] && cmd_full != 16'h0000 && !cmd_full[8])
      load_word = {reg_q[cmd_full[14:9]], 8'h00};
  end

  assign sdo_next = (bit_cnt_q >= 6'd16 && bit_cnt_q < 6'd32) ?
                    data_q[4'd15 - bit_cnt_q[3:0]] : 1'b0;

  always_ff @(posedge aclk) begin
    if (areset) begin
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      sdo_q      <= 1'b0;
      last_cmd_q <= '0;
      err_cnt_q  <= '0;
      tready_q   <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (state_q == S_IDLE && ss_fall) begin
        bit_cnt_q <= '0;
        cmd_q     <= '0;
        sdo_q     <= 1'b0;
      end else if (in_frame) begin
        if (ss_rise) begin
          sdo_q <= 1'b0;
          if (abort && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
          if (sck_rise && bit_cnt_q < 6'd32) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q < 6'd16)  cmd_q  <= cmd_full;
            if (bit_cnt_q == 6'd15) data_q <= load_word;
          end
          if (sck_fall) sdo_q <= sdo_next;
        end
      end else begin
        sdo_q <= 1'b0;
      end
      if (exec) last_cmd_q <= cmd_q;
    end
  end

  assign cmd_rst = (cmd_q == 16'h8500);
  assign cmd_man = (cmd_q[15:14] == 2'b11) && (cmd_q[9:0] == 10'd0) &&
                   (int'(cmd_q[13:10]) < C_NUM_CH);
  assign cmd_wr  = !cmd_q[15] && cmd_q[8];

  for (genvar gi = 0; gi < 64; gi++) begin : g_reg
    localparam logic [7:0] RST_VAL = (gi == 1) ? 8'hFF : 8'h00;
    always_ff @(posedge aclk) begin
      if (areset || (exec && cmd_rst))
        reg_q[gi] <= RST_VAL;
      else if (exec && cmd_wr && cmd_q[14:9] == 6'(gi))
        reg_q[gi] <= cmd_q[7:0];
    end
  end

  // Channels >= C_NUM_CH have no storage, so their beats simply fall through
  for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_samp
    always_ff @(posedge aclk) begin
      if (areset)
        samp_q[gi] <= '0;
      else if (s_axis_tvalid && s_axis_tuser == 3'(gi))
        samp_q[gi] <= s_axis_tdata;
    end
  end

`ifdef ADS868X_EMU_AUTO_SEQ_EN
  assign en_mask  = reg_q[1][C_NUM_CH-1:0];
  assign cmd_auto = (cmd_q == 16'hA000);
`endif

  always_comb begin
    ch_sel_d = ch_sel_q;
`ifdef ADS868X_EMU_AUTO_SEQ_EN
    auto_d  = auto_q;
    nxt_idx = '0;
`endif
    if (exec) begin
      if (cmd_rst) begin
        ch_sel_d = 3'd0;
`ifdef ADS868X_EMU_AUTO_SEQ_EN
        auto_d = 1'b0;
`endif
      end else if (cmd_man) begin
        ch_sel_d = cmd_q[12:10];
`ifdef ADS868X_EMU_AUTO_SEQ_EN
        auto_d = 1'b0;
      end else if (cmd_auto) begin
        auto_d = 1'b1;
        for (int k = C_NUM_CH - 1; k >= 0; k--)
          if (en_mask[k]) ch_sel_d = 3'(k);
      end else if (cmd_q == 16'h0000 && auto_q) begin
        // Descending scan so the nearest enabled channel above ch_sel wins; none -> hold
        for (int k = C_NUM_CH - 1; k >= 1; k--) begin
          nxt_idx = ch_sel_q[CH_W-1:0] + CH_W'(k);
          if (en_mask[nxt_idx]) ch_sel_d = 3'(nxt_idx);
        end
`endif
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ch_sel_q <= 3'd0;
`ifdef ADS868X_EMU_AUTO_SEQ_EN
      auto_q   <= 1'b0;
`endif
    end else begin
      ch_sel_q <= ch_sel_d;
`ifdef ADS868X_EMU_AUTO_SEQ_EN
      auto_q   <= auto_d;
`endif
    end
  end

  assign SDO           = sdo_q;
  assign SDO_T         = sdo_t_c;
  assign s_axis_tready = tready_q;
  assign frame_done    = frame_done_c;
  assign last_cmd      = last_cmd_q;
  assign ch_sel        = ch_sel_q;
  assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_ads868x_spi_emu.sv
// Bench for ads868x_spi_emu: directed frames plus randomized frames/samples against a behavioural model.
`timescale 1ns/1ps
module tb_ads868x_spi_emu;
  localparam int NCH  = 8;
  localparam int HALF = 8;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        SCK = 1'b0, SS_N = 1'b1, SDI = 1'b0;
  logic [15:0] tdata = '0;
  logic [2:0]  tuser = '0;
  logic        tvalid = 1'b0;
  logic        SDO, SDO_T, tready, frame_done;
  logic [15:0] last_cmd;
  logic [2:0]  ch_sel;
  logic [7:0]  err_cnt;

  always #5 aclk = ~aclk;

  ads868x_spi_emu #(.C_NUM_CH(NCH), .C_SYNC_STAGES(2)) dut (
    .aclk(aclk), .areset(areset), .SCK(SCK), .SS_N(SS_N), .SDI(SDI),
    .SDO(SDO), .SDO_T(SDO_T),
    .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .frame_done(frame_done), .last_cmd(last_cmd),
    .ch_sel(ch_sel), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;
  logic [31:0] last_rx;

  always @(negedge aclk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model of the emulated converter
  logic [7:0]  m_regs [64];
  logic [15:0] m_samp [NCH];
  int          m_ch, m_err;
  bit          m_auto;
  logic [15:0] m_last;

  task automatic model_regs_reset();
    for (int a = 0; a < 64; a++) m_regs[a] = (a == 1) ? 8'hFF : 8'h00;
  endtask

  task automatic model_reset();
    model_regs_reset();
    for (int c = 0; c < NCH; c++) m_samp[c] = '0;
    m_ch = 0; m_err = 0; m_auto = 0; m_last = '0;
  endtask

  function automatic logic [31:0] expected_rx(input logic [15:0] cmd);
    if (cmd[15] == 1'b0 && cmd != 16'h0 && cmd[8] == 1'b0)
      return {16'h0, m_regs[cmd[14:9]], 8'h00};
    return {16'h0, m_samp[m_ch]};
  endfunction

  task automatic model_exec(input logic [15:0] cmd);
    int n;
    n = int'(cmd[13:10]);
    if (cmd == 16'h8500) begin
      model_regs_reset(); m_ch = 0; m_auto = 0;
    end else if (cmd[15:14] == 2'b11 && cmd[9:0] == 10'd0) begin
      if (n < NCH) begin m_ch = n; m_auto = 0; end
    end else if (cmd[15] == 1'b0 && cmd[8] == 1'b1) begin
      m_regs[cmd[14:9]] = cmd[7:0];
`ifdef ADS868X_EMU_AUTO_SEQ_EN
    end else if (cmd == 16'hA000) begin
      m_auto = 1;
      for (int c = 0; c < NCH; c++)
        if (m_regs[1][c]) begin m_ch = c; break; end
    end else if (cmd == 16'h0000 && m_auto) begin
      for (int k = 1; k <= NCH; k++)
        if (m_regs[1][(m_ch + k) % NCH]) begin m_ch = (m_ch + k) % NCH; break; end
`endif
    end
  endtask

  task automatic push_sample(input int ch, input logic [15:0] val);
    @(negedge aclk);
    tvalid = 1'b1; tuser = 3'(ch); tdata = val;
    @(negedge aclk);
    tvalid = 1'b0;
    if (ch < NCH) m_samp[ch] = val;
  endtask

  task automatic sck_cycle(input logic d, output logic so);
    SDI = d;
    repeat (HALF) @(negedge aclk);
    so = SDO;
    SCK = 1'b1;
    repeat (HALF) @(negedge aclk);
    SCK = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nclk,
                           output logic [31:0] rx, output logic extra_bad);
    logic so, d;
    rx = '0; extra_bad = 1'b0;
    @(negedge aclk);
    SS_N = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      d = (i < 16) ? cmd[15 - i] : 1'($urandom_range(0, 1));
      sck_cycle(d, so);
      if (i < 32) rx[31 - i] = so;
      else if (so !== 1'b0) extra_bad = 1'b1;
    end
    repeat (HALF) @(negedge aclk);
    SS_N = 1'b1;
    repeat (12) @(negedge aclk);
  endtask

  task automatic do_frame(input logic [15:0] cmd, input int nclk);
    int fd0;
    logic [31:0] exp_rx, rx;
    logic extra_bad;
    fd0 = fd_cnt;
    exp_rx = expected_rx(cmd);
    spi_frame(cmd, nclk, rx, extra_bad);
    last_rx = rx;
    $display("frame cmd=%h clocks=%0d rx=%h ch_sel=%0d err_cnt=%0d", cmd, nclk, rx, ch_sel, err_cnt);
    if (nclk >= 32) begin
      check($sformatf("rx[%h]", cmd), rx, exp_rx);
      model_exec(cmd);
      m_last = cmd;
      check($sformatf("frame_done[%h]", cmd), 32'(fd_cnt - fd0), 32'd1);
    end else begin
      if (m_err < 255) m_err++;
      check($sformatf("short_no_done[%h]", cmd), 32'(fd_cnt - fd0), 32'd0);
    end
    if (nclk > 32) check($sformatf("over_sdo[%h]", cmd), 32'(extra_bad), 32'd0);
    check($sformatf("last_cmd[%h]", cmd), 32'(last_cmd), 32'(m_last));
    check($sformatf("ch_sel[%h]", cmd), 32'(ch_sel), 32'(m_ch));
    check($sformatf("err_cnt[%h]", cmd), 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    logic so;
    int fd0, kind, nclk;
    logic [15:0] cmd;

    model_reset();
    repeat (4) @(negedge aclk);
    check("rst_sdo_t", 32'(SDO_T), 32'd1);
    check("rst_sdo", 32'(SDO), 32'd0);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_last_cmd", 32'(last_cmd), 32'd0);
    check("rst_ch_sel", 32'(ch_sel), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    areset = 1'b0;
    repeat (6) @(negedge aclk);
    check("tready_after_rst", 32'(tready), 32'd1);
    check("idle_sdo_t", 32'(SDO_T), 32'd1);

    // Sample latency: MAN_CH_3 then NO_OP returns ch3
    push_sample(3, 16'h1234);
    do_frame(16'hCC00, 32);
    do_frame(16'h0000, 32);
    check("man_ch3_data", last_rx, 32'h0000_1234);
    check("man_ch3_sel", 32'(ch_sel), 32'd3);

    // Register write then read-back
    do_frame(16'h0B0B, 32);
    do_frame(16'h0A00, 32);
    check("reg5_readback", last_rx, 32'h0000_0B00);

    // Short frame is rejected
    do_frame(16'hC400, 20);
    check("short_err", 32'(err_cnt), 32'd1);
    check("short_ch_kept", 32'(ch_sel), 32'd3);

    // RST command clears registers and channel
    do_frame(16'h0B0B, 32);
    do_frame(16'h8500, 32);
    do_frame(16'h0A00, 32);
    check("rst_cmd_read", last_rx, 32'h0);
    check("rst_cmd_ch", 32'(ch_sel), 32'd0);

    // Reset in the middle of a frame; frame in progress at release is ignored
    @(negedge aclk);
    SS_N = 1'b0;
    for (int i = 0; i < 10; i++) sck_cycle(1'($urandom_range(0, 1)), so);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check("midrst_sdo_t", 32'(SDO_T), 32'd1);
    check("midrst_tready", 32'(tready), 32'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    model_reset();
    fd0 = fd_cnt;
    for (int i = 0; i < 22; i++) begin
      sck_cycle(1'b1, so);
      if (i == 5) check("ignored_sdo_t", 32'(SDO_T), 32'd1);
    end
    repeat (HALF) @(negedge aclk);
    SS_N = 1'b1;
    repeat (12) @(negedge aclk);
    check("ignored_no_done", 32'(fd_cnt - fd0), 32'd0);
    check("ignored_last_cmd", 32'(last_cmd), 32'd0);
    check("ignored_err_cnt", 32'(err_cnt), 32'd0);
    push_sample(2, 16'hBEEF);
    do_frame(16'hC800, 32);
    do_frame(16'h0000, 32);
    check("post_rst_frame", last_rx, 32'h0000_BEEF);

`ifdef ADS868X_EMU_AUTO_SEQ_EN
    for (int c = 0; c < NCH; c++) push_sample(c, 16'hA0A0 + 16'(c));
    do_frame(16'h0305, 32);
    do_frame(16'hA000, 32);
    do_frame(16'h0000, 32);
    check("auto_first", last_rx, 32'h0000_A0A0);
    do_frame(16'h0000, 32);
    check("auto_second", last_rx, 32'h0000_A0A2);
    do_frame(16'h0000, 32);
    check("auto_third", last_rx, 32'h0000_A0A0);
`endif

    // Randomized traffic
    for (int t = 0; t < 45; t++) begin
      for (int s = 0; s < int'($urandom_range(0, 2)); s++)
        push_sample(int'($urandom_range(0, 7)), 16'($urandom));
      kind = int'($urandom_range(0, 8));
      nclk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(33, 36)) : 32;
      case (kind)
        0: cmd = {1'b0, 6'($urandom_range(0, 7)), 1'b1, 8'($urandom)};
        1: cmd = {1'b0, 6'($urandom_range(0, 7)), 1'b0, 8'h00};
        2: cmd = {2'b11, 4'($urandom_range(0, 15)), 10'd0};
        3: cmd = 16'h0000;
        4: cmd = ($urandom_range(0, 2) == 0) ? 16'h8500 : 16'h0000;
        5: cmd = 16'($urandom);
        6: begin cmd = 16'($urandom); nclk = int'($urandom_range(1, 31)); end
        7: cmd = 16'hA000;
        default: cmd = {1'b0, 6'd1, 1'b1, 8'($urandom)};
      endcase
      do_frame(cmd, nclk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
